// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction-fetch memory responder.
// Accepts one word-read request at a time on a valid/ready address channel and
// returns the 32-bit word (or SLVERR) on a valid/ready data channel after a
// configurable number of wait cycles. The word array is preloaded through a
// synchronous write port and is never cleared by reset.
// Optional feature macro: IMEM_RAND_DELAY_EN adds 0..3 extra wait cycles per
// request, taken from an 8-bit LFSR, to model variable memory delay.
module inst_mem_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter is wide enough for LATENCY (max 15) plus the random extra (max 3).
  localparam int          CW       = 5;
  localparam logic [CW-1:0] LAT_W  = CW'(LATENCY);
  // Byte span of the array, compared as 33 bits so 4*DEPTH cannot overflow.
  localparam logic [32:0] SPAN_W   = 33'(DEPTH) * 33'd4;
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_ERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic [1:0]    r_rresp;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic [31:0]   w_roff;
  logic          w_rok;
  logic [AW-1:0] w_ridx;
  logic [31:0]   w_woff;
  logic          w_wok;
  logic [AW-1:0] w_widx;
  logic [CW-1:0] w_lat;

  // Offsets from the array base; below-base addresses wrap to huge offsets,
  // so one unsigned span compare covers both "below base" and "past the end".
  assign w_roff = araddr - BASE_ADDR;
  assign w_rok  = (araddr[1:0] == 2'b00) && (araddr >= BASE_ADDR) &&
                  ({1'b0, w_roff} < SPAN_W);
  assign w_ridx = w_roff[AW+1:2];

  assign w_woff = wr_addr - BASE_ADDR;
  assign w_wok  = (wr_addr[1:0] == 2'b00) && (wr_addr >= BASE_ADDR) &&
                  ({1'b0, w_woff} < SPAN_W);
  assign w_widx = w_woff[AW+1:2];

  assign w_accept = arvalid && (r_state == IDLE);

  // Handshake outputs are decoded straight from the state register so reset
  // takes them to their idle values immediately.
  assign arready = (r_state == IDLE);
  assign rvalid  = (r_state == RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  // x^8+x^6+x^5+x^4+1 Fibonacci feedback taps.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // Extra delay uses the LFSR value from before this request's advance.
  assign w_lat     = LAT_W + {3'b000, r_lfsr[1:0]};

  // Advance the LFSR once per accepted request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end
`else
  assign w_lat = LAT_W;
`endif

  // Preload port: synchronous write, dropped when misaligned or out of range.
  always_ff @(posedge clk) begin
    if (wr_en && w_wok) begin
      r_mem[w_widx] <= wr_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the single-outstanding-request sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = (w_lat == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (rready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Wait counter: loaded at accept, counts down while waiting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_lat;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Response capture at the accept edge; a same-edge preload write is not
  // visible here, so the old word is returned. Held until the next accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata <= '0;
      r_rresp <= RESP_OK;
    end else if (w_accept) begin
      r_rdata <= w_rok ? r_mem[w_ridx] : 32'h0;
      r_rresp <= w_rok ? RESP_OK : RESP_ERR;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: one instance with LATENCY=1 (d=1)
// and one with LATENCY=0 (d=0), sharing clock, reset and the preload port.
module tb_inst_mem_responder;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rstn;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic [31:0] araddr  [2];
  logic        arvalid [2];
  logic        rready  [2];
  logic        arready [2];
  logic        rvalid  [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];

  int errors = 0;
  int checks = 0;

  inst_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h8000_0000), .LATENCY(0)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  inst_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One read transaction on instance d. hold = cycles to keep rready low once
  // rvalid is seen. With same_wr set, a preload write to the same address is
  // driven in the accept cycle. Returns the captured response and the latency
  // counted in edges from the accept edge (accept edge = 1).
  task automatic do_read(input int d, input logic [31:0] addr, input int hold,
                         input bit same_wr, input logic [31:0] wdat,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int lat);
    int wait_n;
    @(negedge clk);
    araddr[d] = addr; arvalid[d] = 1'b1; rready[d] = (hold == 0);
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = addr; wr_data = wdat;
    end
    wait_n = 0;
    while (!arready[d] && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk); #1;
    arvalid[d] = 1'b0; wr_en = 1'b0;
    lat = 1;
    while (!rvalid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    data = rdata[d];
    resp = rresp[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_rvalid", i), {31'b0, rvalid[d]}, 32'h1);
      check($sformatf("hold%0d_rdata", i), rdata[d], data);
      check($sformatf("hold%0d_arready", i), {31'b0, arready[d]}, 32'h0);
    end
    rready[d] = 1'b1;
    @(posedge clk); #1;
    check("post_hs_arready", {31'b0, arready[d]}, 32'h1);
    check("post_hs_rvalid", {31'b0, rvalid[d]}, 32'h0);
    rready[d] = 1'b0;
  endtask

  logic [31:0] d_got;
  logic [1:0]  r_got;
  int          lat_got;

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", {31'b0, arready[1]}, 32'h1);
    check("rst_rvalid", {31'b0, rvalid[1]}, 32'h0);
    check("rst_rdata", rdata[1], 32'h0);
    check("rst_rresp", {30'b0, rresp[1]}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Preload array contents.
    preload(32'h8000_0000, 32'h0000_0413);
    preload(32'h8000_0004, 32'h0010_0073);
    preload(32'h8000_0008, 32'h1111_1111);
    preload(32'h8000_0001, 32'hDEAD_BEEF);  // misaligned: must be dropped

    // 1: LATENCY=1 basic read.
    do_read(1, 32'h8000_0000, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t1_rdata", d_got, 32'h0000_0413);
    check("t1_rresp", {30'b0, r_got}, 32'h0);
    check("t1_latency", lat_got, 32'd2);

    // 2: LATENCY=0 read.
    do_read(0, 32'h8000_0004, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t2_rdata", d_got, 32'h0010_0073);
    check("t2_rresp", {30'b0, r_got}, 32'h0);
    check("t2_latency", lat_got, 32'd1);

    // 3: backpressure for 5 cycles.
    do_read(1, 32'h8000_0004, 5, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t3_rdata", d_got, 32'h0010_0073);

    // 4: error responses.
    do_read(1, 32'h8000_0002, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t4_misal_rresp", {30'b0, r_got}, 32'h2);
    check("t4_misal_rdata", d_got, 32'h0);
    do_read(1, 32'h7FFF_FFFC, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t4_below_rresp", {30'b0, r_got}, 32'h2);
    check("t4_below_rdata", d_got, 32'h0);
    do_read(1, 32'h8000_0000 + 4 * DEPTH, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t4_past_rresp", {30'b0, r_got}, 32'h2);
    check("t4_past_rdata", d_got, 32'h0);
    do_read(0, 32'h8000_0000 + 4 * DEPTH - 4, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t4_last_rresp", {30'b0, r_got}, 32'h0);

    // 5: read and write the same word in the accept cycle.
    do_read(1, 32'h8000_0008, 0, 1'b1, 32'h2222_2222, d_got, r_got, lat_got);
    check("t5_old_rdata", d_got, 32'h1111_1111);
    do_read(1, 32'h8000_0008, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t5_new_rdata", d_got, 32'h2222_2222);

    // 6a: reset during WAIT discards the request.
    @(negedge clk);
    araddr[1] = 32'h8000_0004; arvalid[1] = 1'b1;
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    check("t6_in_wait_arready", {31'b0, arready[1]}, 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_rvalid", {31'b0, rvalid[1]}, 32'h0);
    check("t6_rst_arready", {31'b0, arready[1]}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("t6_rst_held_rvalid", {31'b0, rvalid[1]}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_discarded_rvalid", {31'b0, rvalid[1]}, 32'h0);

    // 6b: reset while RESP is pending drops rvalid at once.
    @(negedge clk);
    araddr[1] = 32'h8000_0000; arvalid[1] = 1'b1; rready[1] = 1'b0;
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    @(posedge clk); #1;
    check("t6_resp_rvalid", {31'b0, rvalid[1]}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("t6_resp_rst_rvalid", {31'b0, rvalid[1]}, 32'h0);
    check("t6_resp_rst_rdata", rdata[1], 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // 6c: normal operation and preserved contents after reset.
    do_read(1, 32'h8000_0000, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t6_after_rdata", d_got, 32'h0000_0413);
    check("t6_after_latency", lat_got, 32'd2);
    do_read(0, 32'h8000_0008, 0, 1'b0, 32'h0, d_got, r_got, lat_got);
    check("t6_after_d0_rdata", d_got, 32'h2222_2222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder that serves the fetch side of the core.
- Accepts word-read requests on a valid/ready address channel and returns 32-bit instruction words on a valid/ready data channel after a configurable latency.
- Backed by an internal word array, preloaded through a simple synchronous write port.
- Replaces the DPI-C pmem read path with synthesizable RTL so the fetch unit can be made multi-cycle.

Parameters:
- DEPTH, 4096, number of 32-bit words in the array.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, number of wait cycles between address accept and response valid (0..15).

Ports:
- clk  input  1  clock, rising-edge.
- rstn  input  1  asynchronous, active-low reset.
- araddr  input  32  fetch byte address.
- arvalid  input  1  request valid.
- arready  output  1  responder can accept a request.
- rdata  output  32  instruction word.
- rresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
- rvalid  output  1  response valid.
- rready  input  1  fetch side accepts response.
- wr_en  input  1  preload write enable.
- wr_addr  input  32  preload byte address.
- wr_data  input  32  preload word.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE, arready=1, rvalid=0, rdata=0, rresp=0, wait counter=0.
  - Array contents are NOT cleared.
- FSM states IDLE, WAIT, RESP:
  - IDLE: arready=1. On arvalid&&arready, latch the address and read/check result, load counter=LATENCY. Next state is RESP if LATENCY==0, else WAIT.
  - WAIT: arready=0, rvalid=0. Counter decrements each cycle; when counter==1, next state is RESP.
  - RESP: rvalid=1, arready=0. rdata/rresp hold stable until rvalid&&rready, then return to IDLE with arready=1 on the next cycle.
- Timing:
  - Request accepted at edge T gives rvalid high from cycle T+1+LATENCY.
  - Single outstanding request; no back-to-back accept while RESP is pending.
- Address check:
  - idx = (araddr-BASE_ADDR)>>2.
  - SLVERR with rdata=0 when araddr[1:0]!=0, araddr<BASE_ADDR, or idx>=DEPTH.
  - Otherwise OKAY with rdata=mem[idx].
  - The address wrapping from 32'hFFFF_FFFC to 0 is not special; it falls under the out-of-range rule.
- Data capture:
  - The array is sampled at the accept edge.
  - A write to the same word in the same cycle returns the old data; the write lands on that edge.
- Preload write port:
  - wr_en writes mem[(wr_addr-BASE_ADDR)>>2]=wr_data on the rising edge.
  - Misaligned or out-of-range writes are silently dropped.
  - Writes are allowed in any FSM state.
- Protocol violations:
  - arvalid while arready=0 is ignored. The requester must hold araddr until accept.
  - rready high while rvalid=0 has no effect.
- Reset mid-operation: the pending request is discarded and rvalid drops immediately.

Optional Feature:
- Macro IMEM_RAND_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advances once per accepted request.
  - Effective latency = LATENCY + lfsr[1:0], using the LFSR value before the advance.
  - Models variable memory delay for fetch-stall testing.
- Not defined: fixed LATENCY; no LFSR logic is present.

Test Plan:
1. Preload mem[0]=32'h0000_0413 via wr_addr=32'h8000_0000. Request araddr=32'h8000_0000 with rready=1 and LATENCY=1 → rvalid at accept+2, rdata=32'h0000_0413, rresp=00, arready back to 1 one cycle after the handshake.
2. LATENCY=0, preload mem[1]=32'h00100073, request 32'h8000_0004 → rvalid at accept+1, rdata=32'h00100073.
3. Hold rready=0 for 5 cycles in RESP → rvalid and rdata stay constant and arready stays 0; raising rready completes with exactly one handshake.
4. Request 32'h8000_0002, then 32'h7FFF_FFFC, then 32'h8000_0000+4*DEPTH → each returns rresp=2'b10, rdata=0.
5. In the same cycle, accept a read of 32'h8000_0008 (old 32'h1111_1111) and write 32'h2222_2222 to it → response 32'h1111_1111; a following read returns 32'h2222_2222.
6. Assert rstn low during WAIT → rvalid=0 and arready=1 immediately; after release, a new request completes normally and preloaded data is intact.
